wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock shared with every pipeline stage.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 pc4_m  input  32  PC+4 of the instruction currently in MEM.
REQ-005 ir_m  input  32  instruction word in MEM.
REQ-006 aluout_m  input  32  ALU result or effective address from MEM.
REQ-007 dmout  input  32  word read from data memory at aluout_m[11:2].
REQ-008 pc4_w  output  32  registered PC+4 of the WB instruction.
REQ-009 ir_w  output  32  registered WB instruction.
REQ-010 regwrite_w  output  1  register-file write enable.
REQ-011 a3_w  output  5  register-file write address.
REQ-012 wd_w  output  32  register-file write data.
REQ-013 retired_cnt  output  32  count of non-nop instructions that have reached WB.

Function
REQ-014 MEM/WB register: on each rising edge without reset, capture pc4_m, ir_m, aluout_m and dmout into pc4_w, ir_w, aluout_w and dm_w; no stall or enable; one-cycle latency MEM to WB.
REQ-015 regwrite_w, a3_w and wd_w SHALL be combinational functions of the registered values only, never of the *_m inputs.
REQ-016 Destination select: R-type addu(100001) and subu(100011) -> rd=ir_w[15:11]; ori(001101), lui(001111), lw(100011), lb(100000), lbu(100100), lh(100001), lhu(100101) -> rt=ir_w[20:16]; jal(000011) -> 31.
REQ-017 All other encodings (sw, beq, j, jr, sll/nop, undefined) SHALL yield regwrite_w=0, a3_w=0, wd_w=0.
REQ-018 If the decoded destination is 0, regwrite_w SHALL be 0 and a3_w SHALL be 0.
REQ-019 Data select: ALU-class -> aluout_w; lw -> dm_w; jal -> pc4_w+4, 32-bit wrap-around.
REQ-020 Byte loads: byte index = aluout_w[1:0], little-endian (index 0 = dm_w[7:0]); lb sign-extends, lbu zero-extends.
REQ-021 Halfword loads: aluout_w[1]=0 selects dm_w[15:0], 1 selects dm_w[31:16]; aluout_w[0] is ignored (no alignment trap); lh sign-extends, lhu zero-extends.
REQ-022 lw SHALL ignore aluout_w[1:0].
REQ-023 retired_cnt SHALL increment by 1 on each rising edge where the pre-edge ir_w is nonzero; it SHALL wrap from 32'hFFFFFFFF to 0.
REQ-024 Bubbles (ir_m=0) SHALL pass through as nops and SHALL NOT write or count.

Reset
REQ-025 While reset=1 at a rising edge, pc4_w, ir_w, aluout_w, dm_w and retired_cnt SHALL clear to 0, giving regwrite_w=0, a3_w=0 and wd_w=0 in the next cycle.
REQ-026 Reset SHALL override capture and counting in the same edge; an instruction in MEM during reset SHALL be discarded.
REQ-027 At the first edge after reset deasserts, the block SHALL resume capture and count only that instruction's successors once they reach WB.

Verification
REQ-028 lw $5: ir_m=8C050000, aluout_m=0x10, dmout=0x12345678, one edge -> regwrite_w=1, a3_w=5, wd_w=0x12345678.
REQ-029 lb/lbu $6: aluout_m=0x13, dmout=0x80FF7F01 -> lb wd_w=0xFFFFFF80; lbu wd_w=0x00000080; lh at aluout_m=0x12 -> 0xFFFF80FF.
REQ-030 jal with pc4_m=0x00003004 -> a3_w=31, wd_w=0x00003008; addu with rd=0 -> regwrite_w=0.
REQ-031 sw, beq and ir=0 in WB -> regwrite_w=0, a3_w=0, wd_w=0; retired_cnt increments for sw and beq but not for the nop.
REQ-032 Stream 5 instructions, assert reset during the 3rd -> all outputs 0 on the next cycle; retired_cnt restarts from 0 and counts only post-reset instructions.
REQ-033 Force retired_cnt to 0xFFFFFFFF with a valid ir_w -> the next edge gives 0.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, register-file write-back decode and retired-instruction counter
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc4_m,
  input  logic [31:0] ir_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] dmout,
  output logic [31:0] pc4_w,
  output logic [31:0] ir_w,
  output logic        regwrite_w,
  output logic [4:0]  a3_w,
  output logic [31:0] wd_w,
  output logic [31:0] retired_cnt
);

  logic [31:0] aluout_w;
  logic [31:0] dm_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc4_w       <= 32'd0;
      ir_w        <= 32'd0;
      aluout_w    <= 32'd0;
      dm_w        <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      pc4_w    <= pc4_m;
      ir_w     <= ir_m;
      aluout_w <= aluout_m;
      dm_w     <= dmout;
      if (ir_w != 32'd0) retired_cnt <= retired_cnt + 32'd1;
    end
  end

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        writes;
  logic [4:0]  dest;
  logic [31:0] wdata;

  assign opcode = ir_w[31:26];
  assign funct  = ir_w[5:0];

  always_comb begin
    load_byte = dm_w[7:0];
    case (aluout_w[1:0])
      2'd0: load_byte = dm_w[7:0];
      2'd1: load_byte = dm_w[15:8];
      2'd2: load_byte = dm_w[23:16];
      2'd3: load_byte = dm_w[31:24];
      default: load_byte = dm_w[7:0];
    endcase
  end

  // Halfword select ignores aluout_w[0]: misaligned halfword loads are not trapped.
  assign load_half = aluout_w[1] ? dm_w[31:16] : dm_w[15:0];

  always_comb begin
    writes = 1'b0;
    dest   = 5'd0;
    wdata  = 32'd0;
    case (opcode)
      6'b000000: begin
        if (funct == 6'b100001 || funct == 6'b100011) begin
          writes = 1'b1;
          dest   = ir_w[15:11];
          wdata  = aluout_w;
        end
      end
      6'b001101, 6'b001111: begin
        writes = 1'b1;
        dest   = ir_w[20:16];
        wdata  = aluout_w;
      end
      6'b100011: begin
        writes = 1'b1;
        dest   = ir_w[20:16];
        wdata  = dm_w;
      end
      6'b100000: begin
        writes = 1'b1;
        dest   = ir_w[20:16];
        wdata  = {{24{load_byte[7]}}, load_byte};
      end
      6'b100100: begin
        writes = 1'b1;
        dest   = ir_w[20:16];
        wdata  = {24'd0, load_byte};
      end
      6'b100001: begin
        writes = 1'b1;
        dest   = ir_w[20:16];
        wdata  = {{16{load_half[15]}}, load_half};
      end
      6'b100101: begin
        writes = 1'b1;
        dest   = ir_w[20:16];
        wdata  = {16'd0, load_half};
      end
      6'b000011: begin
        writes = 1'b1;
        dest   = 5'd31;
        wdata  = pc4_w + 32'd4;
      end
      default: begin
        writes = 1'b0;
      end
    endcase
  end

  // $0 is hardwired: suppress the write and the address, but keep the data path value.
  assign regwrite_w = writes && (dest != 5'd0);
  assign a3_w       = regwrite_w ? dest : 5'd0;
  assign wd_w       = wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with directed instruction vectors
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc4_m;
  logic [31:0] ir_m;
  logic [31:0] aluout_m;
  logic [31:0] dmout;
  logic [31:0] pc4_w;
  logic [31:0] ir_w;
  logic        regwrite_w;
  logic [4:0]  a3_w;
  logic [31:0] wd_w;
  logic [31:0] retired_cnt;

  wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .pc4_m       (pc4_m),
    .ir_m        (ir_m),
    .aluout_m    (aluout_m),
    .dmout       (dmout),
    .pc4_w       (pc4_w),
    .ir_w        (ir_w),
    .regwrite_w  (regwrite_w),
    .a3_w        (a3_w),
    .wd_w        (wd_w),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc4;
    logic [31:0] ir;
    logic        rw;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [31:0] model_ir  = 32'd0;
  bit          stim_done = 1'b0;

  task automatic check(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
    end
  endtask

  // Drive one instruction into MEM; the expected WB state after the next edge goes to the scoreboard.
  task automatic step(input string name, input logic rst, input logic [31:0] pc4, input logic [31:0] ir,
                      input logic [31:0] alu, input logic [31:0] dm,
                      input logic rw, input logic [4:0] a3, input logic [31:0] wd);
    exp_t e;
    reset    = rst;
    pc4_m    = pc4;
    ir_m     = ir;
    aluout_m = alu;
    dmout    = dm;
    if (rst) model_cnt = 32'd0;
    else if (model_ir != 32'd0) model_cnt = model_cnt + 32'd1;
    model_ir = rst ? 32'd0 : ir;
    e.name = name;
    e.pc4  = rst ? 32'd0 : pc4;
    e.ir   = model_ir;
    e.rw   = rw;
    e.a3   = a3;
    e.wd   = wd;
    e.cnt  = model_cnt;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, "pc4_w", pc4_w, e.pc4);
      check(e.name, "ir_w", ir_w, e.ir);
      check(e.name, "regwrite_w", {31'd0, regwrite_w}, {31'd0, e.rw});
      check(e.name, "a3_w", {27'd0, a3_w}, {27'd0, e.a3});
      check(e.name, "wd_w", wd_w, e.wd);
      check(e.name, "retired_cnt", retired_cnt, e.cnt);
    end
  end

  initial begin
    reset = 1'b1; pc4_m = 32'd0; ir_m = 32'd0; aluout_m = 32'd0; dmout = 32'd0;
    @(negedge clk);
    step("reset_discard", 1, 32'h00001000, 32'h8C050000, 32'h10, 32'h12345678, 0, 5'd0, 32'h0);
    step("lw",        0, 32'h00001004, 32'h8C050000, 32'h10, 32'h12345678, 1, 5'd5, 32'h12345678);
    step("lb_b3",     0, 32'h00001008, 32'h80060000, 32'h13, 32'h80FF7F01, 1, 5'd6, 32'hFFFFFF80);
    step("lbu_b3",    0, 32'h0000100C, 32'h90060000, 32'h13, 32'h80FF7F01, 1, 5'd6, 32'h00000080);
    step("lb_b1",     0, 32'h00001010, 32'h80060000, 32'h11, 32'h80FF7F01, 1, 5'd6, 32'h0000007F);
    step("lbu_b2",    0, 32'h00001014, 32'h90060000, 32'h12, 32'h80FF7F01, 1, 5'd6, 32'h000000FF);
    step("lh_hi",     0, 32'h00001018, 32'h84060000, 32'h12, 32'h80FF7F01, 1, 5'd6, 32'hFFFF80FF);
    step("lhu_odd",   0, 32'h0000101C, 32'h94060000, 32'h13, 32'h80FF7F01, 1, 5'd6, 32'h000080FF);
    step("lh_lo",     0, 32'h00001020, 32'h84060000, 32'h11, 32'h80FF7F01, 1, 5'd6, 32'h00007F01);
    step("lw_unalgn", 0, 32'h00001024, 32'h8C050000, 32'h13, 32'hCAFEBABE, 1, 5'd5, 32'hCAFEBABE);
    step("jal",       0, 32'h00003004, 32'h0C000100, 32'h0, 32'h0, 1, 5'd31, 32'h00003008);
    step("addu_rd0",  0, 32'h00003008, 32'h00220021, 32'h55, 32'h0, 0, 5'd0, 32'h00000055);
    step("addu_rd3",  0, 32'h0000300C, 32'h00221821, 32'h1234, 32'h0, 1, 5'd3, 32'h00001234);
    step("subu_rd4",  0, 32'h00003010, 32'h00222023, 32'hFFFFFFFF, 32'h0, 1, 5'd4, 32'hFFFFFFFF);
    step("ori_rt7",   0, 32'h00003014, 32'h34070005, 32'h5, 32'h0, 1, 5'd7, 32'h00000005);
    step("lui_rt8",   0, 32'h00003018, 32'h3C081234, 32'h12340000, 32'h0, 1, 5'd8, 32'h12340000);
    step("sw",        0, 32'h0000301C, 32'hAC050000, 32'h20, 32'h11111111, 0, 5'd0, 32'h0);
    step("beq",       0, 32'h00003020, 32'h10220004, 32'h1, 32'h0, 0, 5'd0, 32'h0);
    step("nop1",      0, 32'h00003024, 32'h00000000, 32'h77, 32'h88, 0, 5'd0, 32'h0);
    step("nop2",      0, 32'h00003028, 32'h00000000, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    step("sll",       0, 32'h0000302C, 32'h00021080, 32'h4, 32'h0, 0, 5'd0, 32'h0);
    step("jal_wrap",  0, 32'hFFFFFFFC, 32'h0C000000, 32'h0, 32'h0, 1, 5'd31, 32'h00000000);
    step("lw_rt0",    0, 32'h00004000, 32'h8C000000, 32'h8, 32'h99, 0, 5'd0, 32'h00000099);
    step("str1_lw",   0, 32'h00005004, 32'h8C090000, 32'h0, 32'hA1, 1, 5'd9, 32'h000000A1);
    step("str2_lw",   0, 32'h00005008, 32'h8C0A0000, 32'h0, 32'hA2, 1, 5'd10, 32'h000000A2);
    step("str3_rst",  1, 32'h0000500C, 32'h8C0B0000, 32'h0, 32'hA3, 0, 5'd0, 32'h0);
    step("str4_lw",   0, 32'h00005010, 32'h8C0C0000, 32'h0, 32'hA4, 1, 5'd12, 32'h000000A4);
    step("str5_lw",   0, 32'h00005014, 32'h8C0D0000, 32'h0, 32'hA5, 1, 5'd13, 32'h000000A5);
    // Preload the counter just below wrap while a valid instruction sits in WB.
    force dut.retired_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retired_cnt;
    model_cnt = 32'hFFFFFFFF;
    step("cnt_wrap",  0, 32'h00005018, 32'h34070001, 32'h1, 32'h0, 1, 5'd7, 32'h00000001);
    step("cnt_after", 0, 32'h0000501C, 32'h00000000, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL timeout: got no completion after 100000 time units, expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
